// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types for the data-memory arbiter:
//   arb_state_e : arbiter FSM states (RUN, DRAIN, HALTED)
//   OWN_CPU / OWN_DBG : encoding of the 1-bit read-owner tag
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/arb_starve_cnt.sv
// ----------------------------------------------------------------------------
// arb_starve_cnt
// Counts consecutive cycles in which the debug port requests and is denied.
// Saturates at STARVE_MAX; clears whenever the request drops or is granted.
// Ports:
//   clk_i, rst_n : clock, asynchronous active-low reset
//   req_i        : debug request present this cycle
//   gnt_i        : debug request granted this cycle
//   at_max_o     : count has reached STARVE_MAX (debug must win next)
// ----------------------------------------------------------------------------
module arb_starve_cnt #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic req_i,
    input  logic gnt_i,
    output logic at_max_o
);

    // +2 keeps the width at least 1 even for STARVE_MAX = 0.
    localparam int unsigned CW = $clog2(STARVE_MAX + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates one synchronous data memory between the CPU MEM stage and a
// debug/loader port. One access per cycle; the debug port can freeze the CPU
// (RUN -> DRAIN -> HALTED) and is protected from starvation by a counter.
//
// Handshake: a requester raises req with all fields and holds them stable
// until issued. CPU is issued in the cycle cpu_stall_o is low with cpu_req_i
// high; debug is issued in the cycle dbg_gnt_o is high. A read issued in cycle
// N returns with a one-cycle rvalid pulse to its owner in cycle N+1.
//
// Ports:
//   clk_i, rst_n                        clock, async active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i       CPU request
//   cpu_stall_o, cpu_rdata_o, cpu_rvalid_o
//   dbg_req_i/we_i/addr_i/wdata_i       debug request
//   dbg_halt_i                          freeze CPU memory access
//   dbg_gnt_o, dbg_halted_o, dbg_rdata_o, dbg_rvalid_o
//   mem_en_o/we_o/addr_o/wdata_o        memory strobes, word index, data
//   mem_rdata_i                         read data, one cycle after a read
//   arb_state_o                         current FSM state (observability)
// ----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_stall_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_rvalid_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    input  logic              dbg_halt_i,
    output logic              dbg_gnt_o,
    output logic              dbg_halted_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_rvalid_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        arb_state_o
);

    arb_state_e        state_q, state_d;
    logic              rd_pend_q, rd_pend_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
    logic              dbg_at_max;
    logic              cpu_gnt, dbg_gnt;

    // Byte-offset bits are not used for word addressing.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{cpu_addr_i[1:0], dbg_addr_i[1:0]};

    // Outside RUN debug is granted whenever it asks, so the counter is
    // naturally zero when the FSM returns to RUN.
    arb_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .req_i   (dbg_req_i),
        .gnt_i   (dbg_gnt),
        .at_max_o(dbg_at_max)
    );

    // Grant selection
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        case (state_q)
            RUN: begin
                if (cpu_req_i && !(dbg_req_i && dbg_at_max)) begin
                    cpu_gnt = 1'b1;
                end else begin
                    dbg_gnt = dbg_req_i;
                end
            end
            default: dbg_gnt = dbg_req_i;
        endcase
    end

    // Memory port driven from the winner, all zero when idle
    always_comb begin
        mem_en_o    = cpu_gnt | dbg_gnt;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (cpu_gnt) begin
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i[ADDR_W-1:2];
            mem_wdata_o = cpu_wdata_i;
        end else if (dbg_gnt) begin
            mem_we_o    = dbg_we_i;
            mem_addr_o  = dbg_addr_i[ADDR_W-1:2];
            mem_wdata_o = dbg_wdata_i;
        end
    end

    // Read tracking: remember that a read left this cycle and who owns it
    always_comb begin
        rd_pend_d = mem_en_o & ~mem_we_o;
        owner_d   = OWN_CPU;
        if (rd_pend_d && dbg_gnt) begin
            owner_d = OWN_DBG;
        end
    end

    // FSM. DRAIN lasts exactly one cycle: no CPU access is issued in DRAIN,
    // so the only CPU response that can be outstanding on entry is delivered
    // during that cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (dbg_halt_i) state_d = DRAIN;
            DRAIN:   state_d = dbg_halt_i ? HALTED : RUN;
            HALTED:  if (!dbg_halt_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            rd_pend_q   <= 1'b0;
            owner_q     <= OWN_CPU;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            owner_q   <= owner_d;
            if (cpu_rvalid_o) cpu_rdata_q <= mem_rdata_i;
            if (dbg_rvalid_o) dbg_rdata_q <= mem_rdata_i;
        end
    end

    // Response path: pass memory data through during the pulse, then hold it
    assign cpu_rvalid_o = rd_pend_q && (owner_q == OWN_CPU);
    assign dbg_rvalid_o = rd_pend_q && (owner_q == OWN_DBG);
    assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : cpu_rdata_q;
    assign dbg_rdata_o  = dbg_rvalid_o ? mem_rdata_i : dbg_rdata_q;

    assign cpu_stall_o  = cpu_req_i & ~cpu_gnt;
    assign dbg_gnt_o    = dbg_gnt;
    assign dbg_halted_o = (state_q == HALTED);
    assign arb_state_o  = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed scenarios followed by randomized traffic, checked every cycle
// against a transaction-level reference model of the arbiter plus a model
// copy of the memory contents.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int STARVE_MAX = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        cpu_req_i = 0, cpu_we_i = 0;
    logic [31:0] cpu_addr_i = 0, cpu_wdata_i = 0;
    logic        cpu_stall_o, cpu_rvalid_o;
    logic [31:0] cpu_rdata_o;
    logic        dbg_req_i = 0, dbg_we_i = 0, dbg_halt_i = 0;
    logic [31:0] dbg_addr_i = 0, dbg_wdata_i = 0;
    logic        dbg_gnt_o, dbg_halted_o, dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;
    logic        mem_en_o, mem_we_o;
    logic [29:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 0;
    logic [1:0]  arb_state_o;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_i(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_stall_o(cpu_stall_o),
        .cpu_rdata_o(cpu_rdata_o), .cpu_rvalid_o(cpu_rvalid_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_halt_i(dbg_halt_i),
        .dbg_gnt_o(dbg_gnt_o), .dbg_halted_o(dbg_halted_o),
        .dbg_rdata_o(dbg_rdata_o), .dbg_rvalid_o(dbg_rvalid_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .arb_state_o(arb_state_o)
    );

    // ---------------- requester intent (applied at negedge) ----------------
    logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0, halt = 0;
    logic [31:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
    bit          rand_mode = 0;

    // ---------------- environment memory ----------------
    logic [31:0] env_mem [16];
    logic        env_en, env_we;
    logic [29:0] env_addr;
    logic [31:0] env_wdata;

    // ---------------- reference model ----------------
    logic [31:0] model_mem [16];
    arb_state_e  m_state;
    int          m_cnt;
    bit          m_pend, m_pend_dbg;
    logic [31:0] m_pend_data, m_cpu_last, m_dbg_last;
    bit          m_cg, m_dg;

    // observed values of the last step, for directed checks
    logic        o_stall, o_dgnt, o_crv, o_drv, o_halted, o_en;
    logic [29:0] o_addr;
    logic [31:0] o_crd, o_drd;

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state    = RUN;
        m_cnt      = 0;
        m_pend     = 0;
        m_pend_dbg = 0;
        m_cpu_last = '0;
        m_dbg_last = '0;
    endtask

    // One clock cycle: drive, predict, compare, then advance model and memory.
    task automatic step();
        logic        e_en, e_we, e_crv, e_drv;
        logic [29:0] e_addr;
        logic [31:0] e_wdata;
        @(negedge clk);
        cpu_req_i = c_req; cpu_we_i = c_we; cpu_addr_i = c_addr; cpu_wdata_i = c_wdata;
        dbg_req_i = d_req; dbg_we_i = d_we; dbg_addr_i = d_addr; dbg_wdata_i = d_wdata;
        dbg_halt_i = halt;
        #1;
        // who wins this cycle
        m_cg = 0; m_dg = 0;
        if (m_state == RUN) begin
            if (c_req && !(d_req && m_cnt == STARVE_MAX)) m_cg = 1;
            else if (d_req) m_dg = 1;
        end else begin
            m_dg = d_req;
        end
        e_en    = m_cg | m_dg;
        e_we    = m_cg ? c_we : (m_dg ? d_we : 1'b0);
        e_addr  = m_cg ? c_addr[31:2] : (m_dg ? d_addr[31:2] : 30'd0);
        e_wdata = m_cg ? c_wdata : (m_dg ? d_wdata : 32'd0);
        e_crv   = m_pend && !m_pend_dbg;
        e_drv   = m_pend && m_pend_dbg;
        check("mem_en", mem_en_o, e_en);
        check("mem_we", mem_we_o, e_we);
        check("mem_addr", mem_addr_o, e_addr);
        check("mem_wdata", mem_wdata_o, e_wdata);
        check("cpu_stall", cpu_stall_o, c_req && !m_cg);
        check("dbg_gnt", dbg_gnt_o, m_dg);
        check("cpu_rvalid", cpu_rvalid_o, e_crv);
        check("dbg_rvalid", dbg_rvalid_o, e_drv);
        check("cpu_rdata", cpu_rdata_o, e_crv ? m_pend_data : m_cpu_last);
        check("dbg_rdata", dbg_rdata_o, e_drv ? m_pend_data : m_dbg_last);
        check("dbg_halted", dbg_halted_o, m_state == HALTED);
        check("arb_state", arb_state_o, m_state);
        o_stall = cpu_stall_o; o_dgnt = dbg_gnt_o; o_crv = cpu_rvalid_o; o_drv = dbg_rvalid_o;
        o_halted = dbg_halted_o; o_en = mem_en_o; o_addr = mem_addr_o;
        o_crd = cpu_rdata_o; o_drd = dbg_rdata_o;
        env_en = mem_en_o; env_we = mem_we_o; env_addr = mem_addr_o; env_wdata = mem_wdata_o;
        @(posedge clk);
        #1;
        // environment memory reacts to what the DUT actually drove
        if (env_en) begin
            if (env_we) env_mem[env_addr[3:0]] = env_wdata;
            else        mem_rdata_i = env_mem[env_addr[3:0]];
        end
        // model advances from its own prediction
        if (m_pend) begin
            if (m_pend_dbg) m_dbg_last = m_pend_data;
            else            m_cpu_last = m_pend_data;
        end
        m_pend = 0;
        if (e_en && !e_we) begin
            m_pend      = 1;
            m_pend_dbg  = m_dg;
            m_pend_data = model_mem[e_addr[3:0]];
        end
        if (e_en && e_we) model_mem[e_addr[3:0]] = e_wdata;
        if (d_req && !m_dg) m_cnt = (m_cnt < STARVE_MAX) ? m_cnt + 1 : m_cnt;
        else                m_cnt = 0;
        case (m_state)
            RUN:     if (halt) m_state = DRAIN;
            DRAIN:   m_state = halt ? HALTED : RUN;
            default: if (!halt) m_state = RUN;
        endcase
        // randomized requesters: drop when issued, maybe start a new access
        if (rand_mode) begin
            if (m_cg) c_req = 0;
            if (m_dg) d_req = 0;
            if (!c_req && $urandom_range(0, 9) < 6) begin
                c_req = 1; c_we = 1'($urandom_range(0, 1));
                c_addr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                c_wdata = $urandom;
            end
            if (!d_req && $urandom_range(0, 9) < 4) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                d_wdata = $urandom;
            end
            if ($urandom_range(0, 99) < 4) halt = ~halt;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            env_mem[i]   = init_word(i);
            model_mem[i] = init_word(i);
        end
        model_reset();

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_rvalid", cpu_rvalid_o, 1'b0);
        check("rst_dbg_rvalid", dbg_rvalid_o, 1'b0);
        check("rst_cpu_rdata", cpu_rdata_o, 32'd0);
        check("rst_dbg_rdata", dbg_rdata_o, 32'd0);
        check("rst_halted", dbg_halted_o, 1'b0);
        check("rst_state", arb_state_o, RUN);
        rst_n = 1'b1;

        // ---- CPU read of 0x10 alone ----
        c_req = 1; c_we = 0; c_addr = 32'h10;
        step();
        check("rd10_addr", o_addr, 30'd4);
        check("rd10_stall", o_stall, 1'b0);
        c_req = 0;
        step();
        check("rd10_rvalid", o_crv, 1'b1);
        check("rd10_rdata", o_crd, init_word(4));

        // ---- both requesting continuously: debug forced through on 5th ----
        c_req = 1; c_we = 0; c_addr = 32'h0C;
        d_req = 1; d_we = 0; d_addr = 32'h18;
        for (int i = 0; i < 6; i++) begin
            step();
            check("starve_gnt", o_dgnt, i == 4);
            check("starve_stall", o_stall, i == 4);
        end
        c_req = 0; d_req = 0;
        step();

        // ---- halt during a CPU read ----
        c_req = 1; c_we = 0; c_addr = 32'h04; halt = 1;
        step();
        check("halt_rd_issue", o_stall, 1'b0);
        c_addr = 32'h08;
        step();
        check("drain_stall", o_stall, 1'b1);
        check("drain_rvalid", o_crv, 1'b1);
        check("drain_rdata", o_crd, init_word(1));
        check("drain_halted", o_halted, 1'b0);
        step();
        check("halted_flag", o_halted, 1'b1);
        check("halted_stall", o_stall, 1'b1);

        // ---- halted: debug write then read back ----
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
        step();
        check("hdbg_wr_gnt", o_dgnt, 1'b1);
        d_we = 0;
        step();
        check("hdbg_rd_gnt", o_dgnt, 1'b1);
        d_req = 0;
        step();
        check("hdbg_rvalid", o_drv, 1'b1);
        check("hdbg_rdata", o_drd, 32'hDEADBEEF);
        check("hdbg_cpu_rvalid", o_crv, 1'b0);

        // ---- release halt: pending CPU read goes out next cycle ----
        halt = 0;
        step();
        check("unhalt_stall0", o_stall, 1'b1);
        step();
        check("unhalt_stall1", o_stall, 1'b0);
        check("unhalt_addr", o_addr, 30'd2);
        c_req = 0;
        step();

        // ---- reset in the middle of a read ----
        c_req = 1; c_we = 0; c_addr = 32'h14;
        step();
        @(negedge clk);
        rst_n = 0; c_req = 0; cpu_req_i = 0; dbg_req_i = 0;
        #1;
        check("midrst_cpu_rvalid", cpu_rvalid_o, 1'b0);
        check("midrst_cpu_rdata", cpu_rdata_o, 32'd0);
        check("midrst_dbg_rdata", dbg_rdata_o, 32'd0);
        check("midrst_halted", dbg_halted_o, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("postrst_rvalid", o_crv | o_drv, 1'b0);
        end

        // ---- randomized traffic ----
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        c_req = 0; d_req = 0; halt = 0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
